// File: rtl/max_spi_arbiter.sv
// Round-robin arbiter sharing the MAX3421E SPI register engine among NUM_REQ requesters.
// Optional grant-to-done timeout with abort is enabled by defining MAX_SPI_ARB_TIMEOUT_EN.
module max_spi_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [NUM_REQ-1:0]   lock_in,
  input  logic [NUM_REQ-1:0]   wr_in,
  input  logic [5*NUM_REQ-1:0] addr_in,
  input  logic [8*NUM_REQ-1:0] wdata_in,
  output logic [NUM_REQ-1:0]   gnt_out,
  output logic [NUM_REQ-1:0]   done_out,
  output logic [NUM_REQ-1:0]   err_out,
  output logic [7:0]           rdata_out,
  output logic                 spi_valid_out,
  input  logic                 spi_ready_in,
  output logic [7:0]           spi_cmd_out,
  output logic [7:0]           spi_data_out,
  input  logic                 spi_done_in,
  input  logic [7:0]           spi_rdata_in,
  output logic                 spi_abort_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 valid_q, valid_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [IW-1:0]        sel_s;
  logic                 done_hit_s;

  // First requesting index strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [7:0] make_cmd(input logic [IW-1:0] idx);
    int i;
    i = int'(idx);
    return {addr_in[5*i +: 5], 1'b0, wr_in[i], 1'b0};
  endfunction

  function automatic logic [7:0] make_data(input logic [IW-1:0] idx);
    int i;
    i = int'(idx);
    return wr_in[i] ? wdata_in[8*i +: 8] : 8'h00;
  endfunction

  assign sel_s      = rr_pick(req_in, rr_q);
  // A done coincident with the command accept counts as completion.
  assign done_hit_s = ((state_q == WAIT) && spi_done_in) ||
                      ((state_q == ISSUE) && spi_ready_in && spi_done_in);

`ifdef MAX_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               abort_q, abort_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    done_d  = '0;
`ifdef MAX_SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_in) begin
          owner_d = sel_s;
          gnt_d   = onehot(sel_s);
          cmd_d   = make_cmd(sel_s);
          data_d  = make_data(sel_s);
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (spi_ready_in) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        state_d = WAIT;
      end
      RELEASE: begin
        if (lock_in[owner_q] && req_in[owner_q]) begin
          cmd_d   = make_cmd(owner_q);
          data_d  = make_data(owner_q);
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (done_hit_s) begin
      rdata_d = spi_rdata_in;
      done_d  = gnt_q;
      rr_d    = owner_q;
      valid_d = 1'b0;
      state_d = RELEASE;
    end else begin
      done_d  = '0;
    end

`ifdef MAX_SPI_ARB_TIMEOUT_EN
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      if (!done_hit_s && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
        err_d   = gnt_q;
        abort_d = 1'b1;
        gnt_d   = '0;
        valid_d = 1'b0;
        rr_d    = owner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
`endif
  end

  // Arbiter state and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      rr_q    <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      valid_q <= 1'b0;
      cmd_q   <= 8'h00;
      data_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MAX_SPI_ARB_TIMEOUT_EN
  // Grant-to-done watchdog and its error/abort pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign err_out       = err_q;
  assign spi_abort_out = abort_q;
`else
  assign err_out       = '0;
  assign spi_abort_out = 1'b0;
`endif

  assign gnt_out       = gnt_q;
  assign done_out      = done_q;
  assign rdata_out     = rdata_q;
  assign spi_valid_out = valid_q;
  assign spi_cmd_out   = cmd_q;
  assign spi_data_out  = data_q;

endmodule

// File: tb/tb_max_spi_arbiter.sv
// Self-checking bench for max_spi_arbiter: transaction table plus hand-written corner cases.
// Completions are checked through a scoreboard queue popped whenever done_out pulses.
module tb_max_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_in, lock_in, wr_in;
  logic [14:0] addr_in;
  logic [23:0] wdata_in;
  logic [2:0]  gnt_out, done_out, err_out;
  logic [7:0]  rdata_out, spi_cmd_out, spi_data_out, spi_rdata_in;
  logic        spi_valid_out, spi_ready_in, spi_done_in, spi_abort_out;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] done;
    logic [7:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    int         lat;
    logic [2:0] gnt;
    logic [7:0] cmd;
    logic [7:0] data;
    int         rdy_dly;
    int         done_dly;
    bit         same_done;
    logic [7:0] rd;
  } vec_t;
  vec_t vecs[11];

  max_spi_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req_in), .lock_in(lock_in),
    .wr_in(wr_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .gnt_out(gnt_out), .done_out(done_out), .err_out(err_out),
    .rdata_out(rdata_out), .spi_valid_out(spi_valid_out), .spi_ready_in(spi_ready_in),
    .spi_cmd_out(spi_cmd_out), .spi_data_out(spi_data_out), .spi_done_in(spi_done_in),
    .spi_rdata_in(spi_rdata_in), .spi_abort_out(spi_abort_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done_out pulse must match the oldest pending completion.
  always @(negedge clk) begin
    if (rst_n && (done_out != 3'b000)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {29'd0, done_out}, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("done_owner", {29'd0, done_out}, {29'd0, e.done});
        chk("done_rdata", {24'd0, rdata_out}, {24'd0, e.rdata});
      end
    end
  end

  task automatic txn(input vec_t v);
    int n;
    req_in  = v.req;
    lock_in = v.lock;
    n = 0;
    do begin
      tick();
      n++;
    end while (!spi_valid_out && n < 20);
    chk("grant_latency", n, v.lat);
    chk("gnt", {29'd0, gnt_out}, {29'd0, v.gnt});
    chk("cmd_data", {16'd0, spi_cmd_out, spi_data_out}, {16'd0, v.cmd, v.data});
    repeat (v.rdy_dly) tick();
    chk("valid_held", {23'd0, spi_valid_out, spi_cmd_out}, {23'd0, 1'b1, v.cmd});
    spi_ready_in = 1'b1;
    if (v.same_done) begin
      spi_done_in  = 1'b1;
      spi_rdata_in = v.rd;
      sb_q.push_back('{done: v.gnt, rdata: v.rd});
      tick();
      spi_ready_in = 1'b0;
      spi_done_in  = 1'b0;
    end else begin
      tick();
      spi_ready_in = 1'b0;
      chk("accept_wait", {28'd0, spi_valid_out, gnt_out}, {28'd0, 1'b0, v.gnt});
      repeat (v.done_dly) tick();
      spi_done_in  = 1'b1;
      spi_rdata_in = v.rd;
      sb_q.push_back('{done: v.gnt, rdata: v.rd});
      tick();
      spi_done_in  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;  req_in = 3'b000;  lock_in = 3'b000;
    wr_in = 3'b101;
    addr_in  = {5'h1F, 5'h13, 5'h11};
    wdata_in = {8'h3C, 8'h77, 8'hA5};
    spi_ready_in = 1'b0;  spi_done_in = 1'b0;  spi_rdata_in = 8'h00;

    //            req     lock    lat gnt     cmd    data   rdy done same rd
    vecs[0]  = '{3'b001, 3'b000, 1, 3'b001, 8'h8A, 8'hA5, 3, 10, 1'b0, 8'h11};
    vecs[1]  = '{3'b111, 3'b000, 2, 3'b010, 8'h98, 8'h00, 0, 2,  1'b0, 8'h5C};
    vecs[2]  = '{3'b111, 3'b000, 2, 3'b100, 8'hFA, 8'h3C, 1, 0,  1'b0, 8'h01};
    vecs[3]  = '{3'b111, 3'b000, 2, 3'b001, 8'h8A, 8'hA5, 0, 0,  1'b1, 8'hE7};
    vecs[4]  = '{3'b111, 3'b000, 2, 3'b010, 8'h98, 8'h00, 2, 1,  1'b0, 8'h42};
    vecs[5]  = '{3'b111, 3'b000, 2, 3'b100, 8'hFA, 8'h3C, 0, 3,  1'b0, 8'h99};
    vecs[6]  = '{3'b011, 3'b001, 2, 3'b001, 8'h8A, 8'hA5, 0, 1,  1'b0, 8'h21};
    vecs[7]  = '{3'b011, 3'b001, 1, 3'b001, 8'h8A, 8'hA5, 1, 0,  1'b0, 8'h22};
    vecs[8]  = '{3'b011, 3'b001, 1, 3'b001, 8'h8A, 8'hA5, 0, 2,  1'b1, 8'h23};
    vecs[9]  = '{3'b011, 3'b000, 2, 3'b010, 8'h98, 8'h00, 1, 4,  1'b0, 8'hC3};
    vecs[10] = '{3'b110, 3'b000, 1, 3'b010, 8'h98, 8'h00, 0, 1,  1'b0, 8'h2D};

    repeat (3) tick();
    chk("reset_outputs", {3'd0, gnt_out, done_out, err_out, spi_valid_out, spi_abort_out,
                          spi_cmd_out, spi_data_out},
        32'd0);
    chk("reset_rdata", {24'd0, rdata_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) txn(vecs[i]);
    req_in  = 3'b000;
    lock_in = 3'b000;
    tick();
    tick();
    chk("idle_after_table", {28'd0, gnt_out, spi_valid_out}, 32'd0);

    // Read with req dropped during WAIT, fields changed after grant, stray done in IDLE.
    req_in = 3'b010;
    tick();
    chk("rd_gnt", {29'd0, gnt_out}, {29'd0, 3'b010});
    addr_in[9:5] = 5'h00;
    wr_in[1]     = 1'b1;
    tick();
    chk("fields_frozen", {16'd0, spi_cmd_out, spi_data_out}, {16'd0, 8'h98, 8'h00});
    spi_ready_in = 1'b1;
    tick();
    spi_ready_in = 1'b0;
    req_in = 3'b000;
    repeat (3) tick();
    spi_done_in  = 1'b1;
    spi_rdata_in = 8'h5C;
    sb_q.push_back('{done: 3'b010, rdata: 8'h5C});
    tick();
    spi_done_in = 1'b0;
    chk("rd_done_pulse", {29'd0, done_out}, {29'd0, 3'b010});
    tick();
    chk("rd_released", {28'd0, gnt_out, done_out[0]}, 32'd0);
    addr_in[9:5] = 5'h13;
    wr_in[1]     = 1'b0;
    spi_done_in  = 1'b1;
    spi_rdata_in = 8'hFF;
    tick();
    spi_done_in = 1'b0;
    tick();
    chk("stray_done_ignored", {21'd0, gnt_out, rdata_out}, {21'd0, 3'b000, 8'h5C});

    // Asynchronous reset in the middle of WAIT.
    req_in = 3'b001;
    tick();
    spi_ready_in = 1'b1;
    tick();
    spi_ready_in = 1'b0;
    tick();
    chk("pre_reset_wait", {28'd0, gnt_out, spi_valid_out}, {28'd0, 3'b001, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {3'd0, gnt_out, done_out, err_out, spi_valid_out, spi_abort_out,
                        spi_cmd_out, spi_data_out},
        32'd0);
    chk("async_reset_rdata", {24'd0, rdata_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    txn(vecs[10]);
    req_in = 3'b000;
    tick();
    tick();

`ifdef MAX_SPI_ARB_TIMEOUT_EN
    req_in = 3'b100;
    tick();
    chk("to_gnt", {29'd0, gnt_out}, {29'd0, 3'b100});
    spi_ready_in = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick();
      spi_ready_in = 1'b0;
    end
    chk("to_not_yet", {28'd0, err_out, spi_abort_out}, 32'd0);
    tick();
    req_in = 3'b000;
    chk("to_err", {24'd0, err_out, spi_abort_out, gnt_out, spi_valid_out, done_out[2]},
        {24'd0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b0});
    tick();
    chk("to_idle", {24'd0, err_out, spi_abort_out, gnt_out, spi_valid_out},
        32'd0);
`else
    req_in = 3'b100;
    tick();
    spi_ready_in = 1'b1;
    tick();
    spi_ready_in = 1'b0;
    req_in = 3'b000;
    repeat (40) tick();
    chk("no_timeout", {25'd0, err_out, spi_abort_out, gnt_out}, {25'd0, 3'b000, 1'b0, 3'b100});
    spi_done_in  = 1'b1;
    spi_rdata_in = 8'h6E;
    sb_q.push_back('{done: 3'b100, rdata: 8'h6E});
    tick();
    spi_done_in = 1'b0;
    tick();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
